restoring_divider: RTL

//  Multi-cycle unsigned 8-bit divider for the ALU arithmetic unit; consumer of the subtractor stage.

---
 rtl/restoring_divider_pkg.sv | 12 +
 rtl/restoring_divider_subtractor.sv | 18 +
 rtl/restoring_divider.sv | 111 +++++++++++
 3 files changed

// File: rtl/restoring_divider_pkg.sv
// Shared definitions for the restoring divider: operand width and FSM states.
package restoring_divider_pkg;

    localparam int unsigned ALU_WIDTH = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/restoring_divider_subtractor.sv
// 8-bit subtractor: Diff = A - B (mod 256), Cout = 1 when no borrow (A >= B).
module subtractor (
    input  logic [7:0] A,
    input  logic [7:0] B,
    output logic [7:0] Diff,
    output logic       Cout
);

    logic [8:0] w_sum;

    // Two's-complement subtraction; the carry out of A + ~B + 1 is the no-borrow flag
    always_comb begin
        w_sum = {1'b0, A} + {1'b0, ~B} + 9'd1;
        Diff  = w_sum[7:0];
        Cout  = w_sum[8];
    end

endmodule

// File: rtl/restoring_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock via a shared subtractor.
module restoring_divider
    import restoring_divider_pkg::*;
#(
    parameter int unsigned          WIDTH        = ALU_WIDTH,
    parameter logic [WIDTH-1:0]     DBZ_QUOTIENT = 8'hFF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t           r_state;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_d;
    logic [2:0]       r_count;

    logic [WIDTH-1:0] w_trial;
    logic [WIDTH-1:0] w_diff;
    logic             w_cout;
    logic             w_take;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;

    subtractor u_sub (
        .A    (w_trial),
        .B    (r_d),
        .Diff (w_diff),
        .Cout (w_cout)
    );

    // One restoring step: shift in the next dividend bit, keep the difference when it fits
    always_comb begin
        w_trial  = {r_r[WIDTH-2:0], r_q[WIDTH-1]};
        w_take   = r_r[WIDTH-1] | w_cout;
        w_r_next = w_take ? w_diff : w_trial;
        w_q_next = {r_q[WIDTH-2:0], w_take};
    end

    // Control FSM with registered datapath and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_q         <= '0;
            r_r         <= '0;
            r_d         <= '0;
            r_count     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_q         <= dividend;
                        r_r         <= '0;
                        r_d         <= divisor;
                        r_count     <= '0;
                        div_by_zero <= 1'b0;
                        busy        <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    // A zero divisor spends its single RUN cycle here so the result
                    // appears one edge after acceptance, keeping DONE a one-cycle state.
                    if (r_d == '0) begin
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= DBZ_QUOTIENT;
                        remainder   <= r_q;
                        div_by_zero <= 1'b1;
                        r_state     <= S_DONE;
                    end else begin
                        r_r     <= w_r_next;
                        r_q     <= w_q_next;
                        r_count <= r_count + 3'd1;
                        if (r_count == 3'd7) begin
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            quotient  <= w_q_next;
                            remainder <= w_r_next;
                            r_state   <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
